// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults for the register scoreboard: sizing of the tracked register
// file, the pending-write counters and the stall-run counter.
package reg_scoreboard_pkg;

   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_IDX_W    = 3;
   localparam int DEF_NUM_SRCS = 2;
   localparam int DEF_CNT_W    = 2;
   localparam int DEF_RUN_W    = 8;

   // Largest number of outstanding writes one register counter can hold
   localparam int CNT_MAX = (2 ** DEF_CNT_W) - 1;

   // All-ones value of a counter of the given width, used for saturation/full tests
   function automatic int max_of_width(input int w);
      return (2 ** w) - 1;
   endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register. Counts writers that
// have issued from decode but not yet retired at writeback. A clear wins over
// any increment/decrement; a decrement of an empty counter is reported as an
// underflow and leaves the count at zero.
module reg_scoreboard_sb_counter
   import reg_scoreboard_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             nz_o,
   output logic             full_o,
   output logic             underflow_o
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, then the inc-only / dec-only cases; inc and dec together cancel
   always_comb begin
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (inc_i && !dec_i) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (dec_i && !inc_i) begin
         if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_ONE;
         end else begin
            underflow_o = 1'b1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign nz_o   = (cnt_q != {CNT_W{1'b0}});
   assign full_o = (cnt_q == CNT_FULL);

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage RAW/WAW interlock. One pending-write counter per architectural
// register replaces per-stage destination compares. Decode stalls when a read
// source still has writers in flight, or when the destination counter is full.
// Stall/issue depend only on registered counters: a register retiring this
// cycle still stalls its readers until the following cycle.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int IDX_W    = DEF_IDX_W,
   parameter int NUM_SRCS = DEF_NUM_SRCS,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int RUN_W    = DEF_RUN_W
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      d_valid_i,
   input  logic [NUM_SRCS-1:0]       d_read_i,
   input  logic [NUM_SRCS*IDX_W-1:0] d_src_idx_i,
   input  logic                      d_regwrite_i,
   input  logic [IDX_W-1:0]          d_dst_idx_i,
   input  logic                      wb_valid_i,
   input  logic                      wb_regwrite_i,
   input  logic [IDX_W-1:0]          wb_dst_idx_i,
   output logic                      d_stall_o,
   output logic                      d_issue_o,
   output logic [NUM_REGS-1:0]       busy_vec_o,
   output logic                      sb_err_o,
   output logic [RUN_W-1:0]          stall_run_o
);

   localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};
   localparam logic [RUN_W-1:0] RUN_SAT = {RUN_W{1'b1}};

   logic [CNT_W-1:0]    cnt_s [NUM_REGS];
   logic [NUM_REGS-1:0] inc_s;
   logic [NUM_REGS-1:0] dec_s;
   logic [NUM_REGS-1:0] nz_s;
   logic [NUM_REGS-1:0] full_s;
   logic [NUM_REGS-1:0] uflow_s;
   logic                raw_hit_s;
   logic                waw_full_s;
   logic                inc_en_s;
   logic                dec_en_s;

   logic                sb_err_q;
   logic                sb_err_d;
   logic [RUN_W-1:0]    stall_run_q;
   logic [RUN_W-1:0]    stall_run_d;

   assign d_stall_o = d_valid_i & (raw_hit_s | waw_full_s);
   assign d_issue_o = d_valid_i & ~d_stall_o & ~flush_i;
   assign inc_en_s  = d_issue_o & d_regwrite_i;
   assign dec_en_s  = wb_valid_i & wb_regwrite_i;

   // Per-register counters with one-hot inc/dec decoders; out-of-range indices match nothing
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign inc_s[r] = inc_en_s & (d_dst_idx_i == IDX_W'(r));
      assign dec_s[r] = dec_en_s & (wb_dst_idx_i == IDX_W'(r));

      reg_scoreboard_sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .inc_i       (inc_s[r]),
         .dec_i       (dec_s[r]),
         .clr_i       (flush_i),
         .cnt_o       (cnt_s[r]),
         .nz_o        (nz_s[r]),
         .full_o      (full_s[r]),
         .underflow_o (uflow_s[r])
      );
   end

   // Source read muxes: any enabled source whose register has pending writers is a RAW hit
   always_comb begin : p_raw
      logic [IDX_W-1:0] src_v;
      raw_hit_s = 1'b0;
      src_v     = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_SRCS; i++) begin
         src_v = d_src_idx_i[i*IDX_W +: IDX_W];
         if (d_read_i[i] && (int'(src_v) < NUM_REGS)) begin
            if (cnt_s[src_v] != {CNT_W{1'b0}}) begin
               raw_hit_s = 1'b1;
            end else begin
               raw_hit_s = raw_hit_s;
            end
         end else begin
            raw_hit_s = raw_hit_s;
         end
      end
   end

   // Destination mux: a write to a register whose counter is saturated must wait
   always_comb begin
      waw_full_s = 1'b0;
      if (d_regwrite_i && (int'(d_dst_idx_i) < NUM_REGS)) begin
         waw_full_s = full_s[d_dst_idx_i];
      end else begin
         waw_full_s = 1'b0;
      end
   end

   // Sticky underflow flag and saturating run length of consecutive stall cycles
   always_comb begin
      sb_err_d    = sb_err_q | (|uflow_s);
      stall_run_d = stall_run_q;
      if (flush_i || !d_stall_o) begin
         stall_run_d = {RUN_W{1'b0}};
      end else if (stall_run_q != RUN_SAT) begin
         stall_run_d = stall_run_q + RUN_ONE;
      end else begin
         stall_run_d = RUN_SAT;
      end
   end

   // Status registers; only rst_ni clears the error flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sb_err_q    <= 1'b0;
         stall_run_q <= {RUN_W{1'b0}};
      end else begin
         sb_err_q    <= sb_err_d;
         stall_run_q <= stall_run_d;
      end
   end

   assign busy_vec_o  = nz_s;
   assign sb_err_o    = sb_err_q;
   assign stall_run_o = stall_run_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. A per-register integer model of pending
// writes is checked against the DUT on every falling edge; literal checks at
// key points pin the model to hand-derived values.
module tb_reg_scoreboard;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       d_valid;
   logic [1:0] d_read;
   logic [5:0] d_src_idx;
   logic       d_regwrite;
   logic [2:0] d_dst_idx;
   logic       wb_valid;
   logic       wb_regwrite;
   logic [2:0] wb_dst_idx;
   logic       d_stall;
   logic       d_issue;
   logic [7:0] busy_vec;
   logic       sb_err;
   logic [7:0] stall_run;

   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 1'b0;

   int  m_cnt [8];
   bit  m_err;
   int  m_run;
   bit  m_st;
   bit  m_iss;

   reg_scoreboard dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .d_valid_i     (d_valid),
      .d_read_i      (d_read),
      .d_src_idx_i   (d_src_idx),
      .d_regwrite_i  (d_regwrite),
      .d_dst_idx_i   (d_dst_idx),
      .wb_valid_i    (wb_valid),
      .wb_regwrite_i (wb_regwrite),
      .wb_dst_idx_i  (wb_dst_idx),
      .d_stall_o     (d_stall),
      .d_issue_o     (d_issue),
      .busy_vec_o    (busy_vec),
      .sb_err_o      (sb_err),
      .stall_run_o   (stall_run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected stall from the interlock rules applied to the model counts
   function automatic bit m_stall();
      bit hit;
      int idx;
      hit = 1'b0;
      if (!d_valid) return 1'b0;
      for (int i = 0; i < 2; i++) begin
         idx = (int'(d_src_idx) >> (3 * i)) & 7;
         if (d_read[i] && m_cnt[idx] > 0) hit = 1'b1;
      end
      if (d_regwrite && m_cnt[d_dst_idx] == 3) hit = 1'b1;
      return hit;
   endfunction

   function automatic int m_busy();
      int b;
      b = 0;
      for (int r = 0; r < 8; r++) if (m_cnt[r] > 0) b |= (1 << r);
      return b;
   endfunction

   // Model state update at each active edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 8; r++) m_cnt[r] = 0;
         m_err = 1'b0;
         m_run = 0;
      end else begin
         m_st  = m_stall();
         m_iss = d_valid && !m_st && !flush;
         if (flush) begin
            for (int r = 0; r < 8; r++) m_cnt[r] = 0;
            m_run = 0;
         end else begin
            m_run = m_st ? ((m_run >= 255) ? 255 : m_run + 1) : 0;
            if (m_iss && d_regwrite && wb_valid && wb_regwrite && d_dst_idx == wb_dst_idx) begin
               m_cnt[d_dst_idx] = m_cnt[d_dst_idx];
            end else begin
               if (m_iss && d_regwrite) m_cnt[d_dst_idx] = m_cnt[d_dst_idx] + 1;
               if (wb_valid && wb_regwrite) begin
                  if (m_cnt[wb_dst_idx] > 0) m_cnt[wb_dst_idx] = m_cnt[wb_dst_idx] - 1;
                  else m_err = 1'b1;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("m_d_stall", int'(d_stall), int'(m_stall()));
         chk("m_d_issue", int'(d_issue), int'(d_valid && !m_stall() && !flush));
         chk("m_busy_vec", int'(busy_vec), m_busy());
         chk("m_sb_err", int'(sb_err), int'(m_err));
         chk("m_stall_run", int'(stall_run), m_run);
      end
   end

   task automatic drv(input bit v, input bit [1:0] rd, input int s0, input int s1,
                      input bit rw, input int dst, input bit wbv, input int wbd, input bit fl);
      d_valid     = v;
      d_read      = rd;
      d_src_idx   = {3'(s1), 3'(s0)};
      d_regwrite  = rw;
      d_dst_idx   = 3'(dst);
      wb_valid    = wbv;
      wb_regwrite = wbv;
      wb_dst_idx  = 3'(wbd);
      flush       = fl;
   endtask

   task automatic idle();
      drv(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      step(2);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      step(1);

      // 1: reads of idle registers do not stall
      drv(1'b1, 2'b11, 3, 4, 1'b0, 0, 1'b0, 0, 1'b0);
      @(negedge clk);
      chk("t1_stall", int'(d_stall), 0);
      chk("t1_busy", int'(busy_vec), 0);
      chk("t1_issue", int'(d_issue), 1);
      step(1);

      // 2: RAW on r5, writeback does not bypass
      drv(1'b1, 2'b00, 0, 0, 1'b1, 5, 1'b0, 0, 1'b0);
      step(1);
      drv(1'b1, 2'b01, 5, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      @(negedge clk);
      chk("t2_stall", int'(d_stall), 1);
      chk("t2_busy", int'(busy_vec), 8'h20);
      step(1);
      drv(1'b1, 2'b01, 5, 0, 1'b0, 0, 1'b1, 5, 1'b0);
      @(negedge clk);
      chk("t2_stall_wb", int'(d_stall), 1);
      step(1);
      drv(1'b1, 2'b01, 5, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      @(negedge clk);
      chk("t2_unstall", int'(d_stall), 0);
      chk("t2_busy_clr", int'(busy_vec), 0);
      step(1);

      // 3: three writes fill r2, the fourth waits for one retire
      drv(1'b1, 2'b00, 0, 0, 1'b1, 2, 1'b0, 0, 1'b0);
      step(3);
      @(negedge clk);
      chk("t3_waw_stall", int'(d_stall), 1);
      chk("t3_busy", int'(busy_vec), 8'h04);
      step(1);
      drv(1'b1, 2'b00, 0, 0, 1'b1, 2, 1'b1, 2, 1'b0);
      @(negedge clk);
      chk("t3_stall_wb", int'(d_stall), 1);
      step(1);
      drv(1'b1, 2'b00, 0, 0, 1'b1, 2, 1'b0, 0, 1'b0);
      @(negedge clk);
      chk("t3_issue4", int'(d_issue), 1);
      step(1);
      @(negedge clk);
      chk("t3_full_again", int'(d_stall), 1);

      // 4: simultaneous issue and retire on r1 leaves the count unchanged
      drv(1'b1, 2'b00, 0, 0, 1'b1, 1, 1'b0, 0, 1'b0);
      step(1);
      drv(1'b1, 2'b00, 0, 0, 1'b1, 1, 1'b1, 1, 1'b0);
      @(negedge clk);
      chk("t4_issue", int'(d_issue), 1);
      step(1);
      idle();
      @(negedge clk);
      chk("t4_busy", int'(busy_vec), 8'h06);
      drv(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b1, 1, 1'b0);
      step(1);
      idle();
      @(negedge clk);
      chk("t4_busy_after_wb", int'(busy_vec), 8'h04);

      // 5: flush clears every counter and the stall run
      drv(1'b1, 2'b00, 0, 0, 1'b1, 0, 1'b0, 0, 1'b0);
      step(2);
      drv(1'b1, 2'b00, 0, 0, 1'b1, 6, 1'b0, 0, 1'b0);
      step(1);
      idle();
      @(negedge clk);
      chk("t5_busy", int'(busy_vec), 8'h45);
      drv(1'b1, 2'b01, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      step(3);
      @(negedge clk);
      chk("t5_run3", int'(stall_run), 3);
      drv(1'b1, 2'b00, 0, 0, 1'b1, 3, 1'b0, 0, 1'b1);
      @(negedge clk);
      chk("t5_flush_issue", int'(d_issue), 0);
      step(1);
      idle();
      @(negedge clk);
      chk("t5_busy_flushed", int'(busy_vec), 0);
      chk("t5_run_flushed", int'(stall_run), 0);

      // 6: underflow is sticky, stall run saturates, reset clears at once
      drv(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b1, 7, 1'b0);
      step(1);
      idle();
      @(negedge clk);
      chk("t6_err", int'(sb_err), 1);
      chk("t6_busy7", int'(busy_vec), 0);
      step(5);
      @(negedge clk);
      chk("t6_err_held", int'(sb_err), 1);
      drv(1'b1, 2'b00, 0, 0, 1'b1, 4, 1'b0, 0, 1'b0);
      step(1);
      drv(1'b1, 2'b10, 0, 4, 1'b0, 0, 1'b0, 0, 1'b0);
      step(300);
      @(negedge clk);
      chk("t6_run_sat", int'(stall_run), 255);
      chk("t6_stall", int'(d_stall), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", int'(busy_vec), 0);
      chk("t6_rst_err", int'(sb_err), 0);
      chk("t6_rst_run", int'(stall_run), 0);
      chk("t6_rst_stall", int'(d_stall), 0);
      idle();
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
